// File: rtl/jelly2_multi_interval_timer.sv
// Multi-channel interval timer on a zero-wait WISHBONE slave port.
// Each channel has a prescaler, a compare match with optional auto-reload, and a W1C pending flag.
module jelly2_multi_interval_timer #(
   parameter int NUM_CH         = 4,
   parameter int CH_BITS        = 2,
   parameter int WB_ADR_WIDTH   = 8,
   parameter int WB_DAT_WIDTH   = 32,
   parameter int COUNT_WIDTH    = 32,
   parameter int PRESCALE_WIDTH = 16,
   parameter int IRQ_LEVEL      = 1,
   parameter int WB_SEL_WIDTH   = WB_DAT_WIDTH / 8
) (
   input  logic                      aresetn,
   input  logic                      aclk,
   input  logic                      cke,
   input  logic [WB_ADR_WIDTH-1:0]   s_wb_adr_i,
   input  logic [WB_DAT_WIDTH-1:0]   s_wb_dat_i,
   output logic [WB_DAT_WIDTH-1:0]   s_wb_dat_o,
   input  logic                      s_wb_we_i,
   input  logic [WB_SEL_WIDTH-1:0]   s_wb_sel_i,
   input  logic                      s_wb_stb_i,
   output logic                      s_wb_ack_o,
   output logic [NUM_CH-1:0]         irq
);

   localparam logic [1:0] REG_CTL = 2'd0;
   localparam logic [1:0] REG_CMP = 2'd1;
   localparam logic [1:0] REG_CNT = 2'd2;
   localparam logic [1:0] REG_STS = 2'd3;

   logic                      en        [NUM_CH];
   logic                      auto_rld  [NUM_CH];
   logic                      ie        [NUM_CH];
   logic [PRESCALE_WIDTH-1:0] prescale  [NUM_CH];
   logic [PRESCALE_WIDTH-1:0] psc       [NUM_CH];
   logic [COUNT_WIDTH-1:0]    compare   [NUM_CH];
   logic [COUNT_WIDTH-1:0]    counter   [NUM_CH];
   logic                      pending   [NUM_CH];
   logic                      irq_pulse [NUM_CH];

   logic [CH_BITS-1:0]        sel_ch;
   logic [1:0]                sel_reg;
   logic                      ch_valid;
   logic                      wr_en;
   logic                      sts_clr;
   logic [WB_DAT_WIDTH-1:0]   rd_img;
   logic [WB_DAT_WIDTH-1:0]   wr_val;
   logic                      wr_ctl [NUM_CH];
   logic                      wr_cmp [NUM_CH];
   logic                      wr_cnt [NUM_CH];
   logic                      wr_sts [NUM_CH];
   logic                      tick   [NUM_CH];
   logic                      expire [NUM_CH];
   logic                      unused_adr;

   function automatic logic [WB_DAT_WIDTH-1:0] byte_merge(
      input logic [WB_DAT_WIDTH-1:0] cur,
      input logic [WB_DAT_WIDTH-1:0] wdat,
      input logic [WB_SEL_WIDTH-1:0] bsel
   );
      logic [WB_DAT_WIDTH-1:0] r;
      r = cur;
      for (int b = 0; b < WB_SEL_WIDTH; b++) begin
         if (bsel[b]) r[8*b +: 8] = wdat[8*b +: 8];
      end
      return r;
   endfunction

   assign sel_ch     = s_wb_adr_i[CH_BITS+1:2];
   assign sel_reg    = s_wb_adr_i[1:0];
   assign ch_valid   = (int'(sel_ch) < NUM_CH);
   assign wr_en      = s_wb_stb_i & s_wb_we_i & ch_valid;
   assign sts_clr    = s_wb_dat_i[0] & s_wb_sel_i[0];
   assign s_wb_ack_o = s_wb_stb_i;
   assign unused_adr = &{1'b0, s_wb_adr_i};

   // Read image of the addressed register; the write value is that image with the selected bytes replaced.
   always_comb begin
      rd_img = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_valid && sel_ch == CH_BITS'(i)) begin
            case (sel_reg)
               REG_CTL: begin
                  rd_img[0]                   = en[i];
                  rd_img[1]                   = auto_rld[i];
                  rd_img[2]                   = ie[i];
                  rd_img[16 +: PRESCALE_WIDTH] = prescale[i];
               end
               REG_CMP: rd_img[COUNT_WIDTH-1:0] = compare[i];
               REG_CNT: rd_img[COUNT_WIDTH-1:0] = counter[i];
               default: rd_img[0]               = pending[i];
            endcase
         end
      end
   end

   assign s_wb_dat_o = rd_img;
   assign wr_val     = byte_merge(rd_img, s_wb_dat_i, s_wb_sel_i);

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         wr_ctl[i] = wr_en && sel_ch == CH_BITS'(i) && sel_reg == REG_CTL;
         wr_cmp[i] = wr_en && sel_ch == CH_BITS'(i) && sel_reg == REG_CMP;
         wr_cnt[i] = wr_en && sel_ch == CH_BITS'(i) && sel_reg == REG_CNT;
         wr_sts[i] = wr_en && sel_ch == CH_BITS'(i) && sel_reg == REG_STS;
         // A counter load restarts the count, so it swallows a coincident tick.
         tick[i]   = en[i] && cke && psc[i] == prescale[i] && !wr_cnt[i];
         expire[i] = tick[i] && counter[i] == compare[i];
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < NUM_CH; i++) begin
            en[i]        <= 1'b0;
            auto_rld[i]  <= 1'b0;
            ie[i]        <= 1'b0;
            prescale[i]  <= '0;
            psc[i]       <= '0;
            compare[i]   <= '0;
            counter[i]   <= '0;
            pending[i]   <= 1'b0;
            irq_pulse[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr_ctl[i]) begin
               en[i]       <= wr_val[0];
               auto_rld[i] <= wr_val[1];
               ie[i]       <= wr_val[2];
               prescale[i] <= wr_val[16 +: PRESCALE_WIDTH];
            end else if (expire[i] && !auto_rld[i]) begin
               en[i] <= 1'b0;
            end

            if (wr_cmp[i]) compare[i] <= wr_val[COUNT_WIDTH-1:0];

            if (wr_cnt[i]) begin
               counter[i] <= wr_val[COUNT_WIDTH-1:0];
               psc[i]     <= '0;
            end else begin
               if ((wr_ctl[i] && wr_val[0] && !en[i]) || tick[i]) psc[i] <= '0;
               else if (en[i] && cke)                               psc[i] <= psc[i] + 1'b1;
               if (tick[i]) counter[i] <= expire[i] ? '0 : counter[i] + 1'b1;
            end

            if (expire[i])                    pending[i] <= 1'b1;
            else if (wr_sts[i] && sts_clr)    pending[i] <= 1'b0;

            irq_pulse[i] <= expire[i] & ie[i];
         end
      end
   end

   always_comb begin
      irq = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         irq[i] = (IRQ_LEVEL != 0) ? (pending[i] & ie[i]) : irq_pulse[i];
      end
   end

endmodule

// File: tb/tb_jelly2_multi_interval_timer.sv
// Bench for jelly2_multi_interval_timer: a pulse-mode and a level-mode instance (NUM_CH=3) share one bus.
module tb_jelly2_multi_interval_timer;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        cke = 1'b1;
   logic [7:0]  adr = '0;
   logic [31:0] wdat = '0;
   logic        we = 1'b0;
   logic [3:0]  sel = '0;
   logic        stb = 1'b0;

   logic [31:0] dat_p, dat_l;
   logic        ack_p, ack_l;
   logic [2:0]  irq_p, irq_l;

   int n_vec = 0;
   int n_err = 0;

   always #5 aclk = ~aclk;

   jelly2_multi_interval_timer #(.NUM_CH(3), .CH_BITS(2), .IRQ_LEVEL(0)) dut_p (
      .aresetn(aresetn), .aclk(aclk), .cke(cke),
      .s_wb_adr_i(adr), .s_wb_dat_i(wdat), .s_wb_dat_o(dat_p), .s_wb_we_i(we),
      .s_wb_sel_i(sel), .s_wb_stb_i(stb), .s_wb_ack_o(ack_p), .irq(irq_p));

   jelly2_multi_interval_timer #(.NUM_CH(3), .CH_BITS(2), .IRQ_LEVEL(1)) dut_l (
      .aresetn(aresetn), .aclk(aclk), .cke(cke),
      .s_wb_adr_i(adr), .s_wb_dat_i(wdat), .s_wb_dat_o(dat_l), .s_wb_we_i(we),
      .s_wb_sel_i(sel), .s_wb_stb_i(stb), .s_wb_ack_o(ack_l), .irq(irq_l));

   typedef struct {
      logic        wr;
      logic [7:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [7:0] ra(input int ch, input int r);
      return 8'(ch * 4 + r);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Bus tasks are entered 1 time unit after a rising edge; the access completes at the next edge.
   task automatic wb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      adr = a; wdat = d; sel = s; we = 1'b1; stb = 1'b1;
      @(posedge aclk); #1;
      stb = 1'b0; we = 1'b0;
   endtask

   task automatic wb_read(input logic [7:0] a, output logic [31:0] d, output logic ack);
      adr = a; sel = 4'hF; we = 1'b0; stb = 1'b1;
      #3;
      d = dat_p; ack = ack_p;
      @(posedge aclk); #1;
      stb = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   logic [31:0] rd;
   logic        ack;
   int          pulses;

   initial begin
      tbl.push_back('{1'b1, ra(0,0), 32'hFFFF_FFF6, 4'hF, 32'h0});
      tbl.push_back('{1'b0, ra(0,0), 32'h0,         4'hF, 32'hFFFF_0006});
      tbl.push_back('{1'b1, ra(0,0), 32'h0,         4'h4, 32'h0});
      tbl.push_back('{1'b0, ra(0,0), 32'h0,         4'hF, 32'hFF00_0006});
      tbl.push_back('{1'b1, ra(0,1), 32'h1234_5678, 4'hF, 32'h0});
      tbl.push_back('{1'b0, ra(0,1), 32'h0,         4'hF, 32'h1234_5678});
      tbl.push_back('{1'b1, ra(0,1), 32'hAABB_CCDD, 4'h9, 32'h0});
      tbl.push_back('{1'b0, ra(0,1), 32'h0,         4'hF, 32'hAA34_56DD});
      tbl.push_back('{1'b1, ra(1,2), 32'hDEAD_BEEF, 4'hF, 32'h0});
      tbl.push_back('{1'b0, ra(1,2), 32'h0,         4'hF, 32'hDEAD_BEEF});
      tbl.push_back('{1'b1, ra(1,3), 32'h1,         4'hF, 32'h0});
      tbl.push_back('{1'b0, ra(1,3), 32'h0,         4'hF, 32'h0});
      tbl.push_back('{1'b1, ra(3,0), 32'hFFFF_FFFF, 4'hF, 32'h0});
      tbl.push_back('{1'b1, ra(3,1), 32'hFFFF_FFFF, 4'hF, 32'h0});
      tbl.push_back('{1'b0, ra(3,0), 32'h0,         4'hF, 32'h0});
      tbl.push_back('{1'b0, ra(3,1), 32'h0,         4'hF, 32'h0});
      tbl.push_back('{1'b0, ra(0,0), 32'h0,         4'hF, 32'hFF00_0006});
      tbl.push_back('{1'b1, ra(0,0), 32'h0,         4'hF, 32'h0});
      tbl.push_back('{1'b1, ra(0,1), 32'h0,         4'hF, 32'h0});
      tbl.push_back('{1'b1, ra(1,2), 32'h0,         4'hF, 32'h0});
      tbl.push_back('{1'b0, ra(0,0), 32'h0,         4'hF, 32'h0});

      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;
      check("reset_irq_p", 32'(irq_p), 32'h0);
      check("reset_irq_l", 32'(irq_l), 32'h0);
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            wb_read(ra(c, r), rd, ack);
            check($sformatf("reset_rd_ch%0d_r%0d", c, r), rd, 32'h0);
         end
      end

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].wr) begin
            adr = tbl[i].a; wdat = tbl[i].d; sel = tbl[i].s; we = 1'b1; stb = 1'b1;
            #3;
            check($sformatf("vec%0d_ack", i), 32'(ack_p), 32'h1);
            @(posedge aclk); #1;
            stb = 1'b0; we = 1'b0;
         end else begin
            wb_read(tbl[i].a, rd, ack);
            check($sformatf("vec%0d_ack", i), 32'(ack), 32'h1);
            check($sformatf("vec%0d_rd", i), rd, tbl[i].exp);
         end
      end

      // ch0 auto-reload, pulse irq every 10 cycles
      wb_write(ra(0,1), 32'd9, 4'hF);
      wb_write(ra(0,0), 32'h7, 4'hF);
      for (int k = 1; k <= 30; k++) begin
         cycles(1);
         check($sformatf("ch0_pulse_k%0d", k), 32'(irq_p[0]), 32'((k % 10) == 0));
      end
      wb_write(ra(0,0), 32'h0, 4'hF);
      wb_write(ra(0,3), 32'h1, 4'hF);
      wb_write(ra(0,2), 32'h0, 4'hF);

      // ch1 one-shot, prescale 3, compare 4 -> pending at 20 cycles
      wb_write(ra(1,1), 32'd4, 4'hF);
      wb_write(ra(1,0), 32'h0003_0005, 4'hF);
      cycles(19);
      check("ch1_lvl_c19", 32'(irq_l[1]), 32'h0);
      check("ch1_pls_c19", 32'(irq_p[1]), 32'h0);
      cycles(1);
      check("ch1_lvl_c20", 32'(irq_l[1]), 32'h1);
      check("ch1_pls_c20", 32'(irq_p[1]), 32'h1);
      wb_read(ra(1,0), rd, ack);
      check("ch1_ctl_en_clr", rd, 32'h0003_0004);
      pulses = 0;
      for (int k = 0; k < 200; k++) begin
         cycles(1);
         if (irq_p[1]) pulses++;
      end
      check("ch1_no_reexpiry", 32'(pulses), 32'h0);
      wb_read(ra(1,3), rd, ack);
      check("ch1_pending", rd, 32'h1);
      wb_write(ra(1,3), 32'h1, 4'hF);
      check("ch1_irq_after_w1c", 32'(irq_l[1]), 32'h0);
      wb_read(ra(1,3), rd, ack);
      check("ch1_status_clr", rd, 32'h0);

      // ch2 expiry every cycle; W1C loses to set
      wb_write(ra(2,0), 32'h3, 4'hF);
      for (int k = 0; k < 10; k++) wb_write(ra(2,3), 32'h1, 4'hF);
      wb_read(ra(2,3), rd, ack);
      check("ch2_set_wins", rd, 32'h1);
      wb_write(ra(2,0), 32'h0, 4'hF);
      wb_write(ra(2,3), 32'h1, 4'hF);
      wb_read(ra(2,3), rd, ack);
      check("ch2_cleared", rd, 32'h0);

      // ch0 COUNTER load close to COMPARE
      wb_write(ra(0,1), 32'd100, 4'hF);
      wb_write(ra(0,0), 32'h7, 4'hF);
      wb_write(ra(0,2), 32'd98, 4'hF);
      cycles(2);
      check("ch0_load_c2_p", 32'(irq_p[0]), 32'h0);
      check("ch0_load_c2_l", 32'(irq_l[0]), 32'h0);
      cycles(1);
      check("ch0_load_c3_p", 32'(irq_p[0]), 32'h1);
      check("ch0_load_c3_l", 32'(irq_l[0]), 32'h1);
      wb_write(ra(0,3), 32'h1, 4'hF);
      wb_write(ra(0,2), 32'd50, 4'hF);
      wb_write(ra(0,1), 32'd5, 4'hF);
      pulses = 0;
      for (int k = 0; k < 100; k++) begin
         cycles(1);
         if (irq_p[0]) pulses++;
      end
      check("ch0_cmp_below_no_exp", 32'(pulses), 32'h0);
      wb_read(ra(0,3), rd, ack);
      check("ch0_cmp_below_status", rd, 32'h0);

      // cke held low for 7 cycles delays the expiry by 7
      wb_write(ra(0,0), 32'h0, 4'hF);
      wb_write(ra(0,3), 32'h1, 4'hF);
      wb_write(ra(0,2), 32'h0, 4'hF);
      wb_write(ra(0,1), 32'd9, 4'hF);
      wb_write(ra(0,0), 32'h7, 4'hF);
      cycles(3);
      cke = 1'b0;
      cycles(7);
      cke = 1'b1;
      cycles(6);
      check("cke_c16", 32'(irq_p[0]), 32'h0);
      cycles(1);
      check("cke_c17", 32'(irq_p[0]), 32'h1);

      // reset in the middle of counting
      wb_write(ra(1,1), 32'd4, 4'hF);
      wb_write(ra(1,0), 32'h7, 4'hF);
      wb_write(ra(2,0), 32'h7, 4'hF);
      cycles(5);
      check("pre_reset_irq2", 32'(irq_l[2]), 32'h1);
      aresetn = 1'b0;
      #2;
      check("in_reset_irq_p", 32'(irq_p), 32'h0);
      check("in_reset_irq_l", 32'(irq_l), 32'h0);
      cycles(2);
      aresetn = 1'b1;
      check("post_reset_irq_l", 32'(irq_l), 32'h0);
      for (int c = 0; c < 3; c++) begin
         for (int r = 0; r < 4; r++) begin
            wb_read(ra(c, r), rd, ack);
            check($sformatf("post_reset_ch%0d_r%0d", c, r), rd, 32'h0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
